// File: rtl/pktctrl_pkg.sv
// Shared constants for the packet-control self-test checker.
// Holds FSM state encodings, lane/sample widths and ramp STEP values.
package pktctrl_pkg;

   localparam int LANE_W = 36;
   localparam int SMP_W  = 12;

   localparam logic [1:0] CHK_IDLE  = 2'd0;
   localparam logic [1:0] CHK_SYNC  = 2'd1;
   localparam logic [1:0] CHK_CHECK = 2'd2;

   localparam logic [SMP_W-1:0] STEP_96 = 12'd72;
   localparam logic [SMP_W-1:0] STEP_48 = 12'd36;

endpackage

// File: rtl/pkt_lane_cmp.sv
// Combinational compare of one lane word against the ramp pattern.
// Ports: word (36b lane), base (ramp base), active (lane in use),
//        mism (1 = lane word does not match / inactive lane nonzero).
module pkt_lane_cmp
   import pktctrl_pkg::*;
#(
   parameter int LANE_IDX = 0
) (
   input  logic [LANE_W-1:0] word,
   input  logic [SMP_W-1:0]  base,
   input  logic              active,
   output logic              mism
);

   logic [SMP_W-1:0] lane_off;
   logic [SMP_W-1:0] s0;
   logic [SMP_W-1:0] s1;
   logic [SMP_W-1:0] s2;

   // first sample of lane i sits 3*i after the base, modulo 2^SMP_W
   assign lane_off = SMP_W'(3 * LANE_IDX);
   assign s0 = base + lane_off;
   assign s1 = s0 + 12'd1;
   assign s2 = s0 + 12'd2;

   assign mism = active ? (word != {s2, s1, s0})
                        : (word != '0);

endmodule

// File: rtl/package_data_chk.sv
// Self-test checker for packaged ADC lane words against the ramp.
// Ports: clk, rst_n, rf_chk_en, rf_chk_clr, rf_96path_en, data_vld,
//        data (NUM_LANE x 36b); out: chk_state, chk_locked,
//        chk_lane_err (sticky), chk_err_cnt, chk_word_cnt.
module package_data_chk #(
   parameter int NUM_LANE  = 24,
   parameter int SMP_W     = 12,
   parameter int SYNC_CNT  = 4,
   parameter int ERR_LIMIT = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     rf_chk_en,
   input  logic                     rf_chk_clr,
   input  logic                     rf_96path_en,
   input  logic                     data_vld,
   input  logic [NUM_LANE*36-1:0]   data,
   output logic [1:0]               chk_state,
   output logic                     chk_locked,
   output logic [NUM_LANE-1:0]      chk_lane_err,
   output logic [15:0]              chk_err_cnt,
   output logic [31:0]              chk_word_cnt
);

   import pktctrl_pkg::*;

   localparam int MC_W = $clog2(SYNC_CNT + 1);
   localparam int ER_W = $clog2(ERR_LIMIT + 1);

   logic [1:0]          state;
   logic                mode96;
   logic [SMP_W-1:0]    exp_base;
   logic [SMP_W-1:0]    cand;
   logic [SMP_W-1:0]    ref_base;
   logic [SMP_W-1:0]    step;
   logic [MC_W-1:0]     match_cnt;
   logic [MC_W-1:0]     match_nxt;
   logic [ER_W-1:0]     err_run;
   logic [ER_W-1:0]     run_nxt;
   logic [NUM_LANE-1:0] active;
   logic [NUM_LANE-1:0] mism;
   logic                consistent;
   logic                any_err;

   assign cand = data[SMP_W-1:0];
   assign step = mode96 ? STEP_96 : STEP_48;

   // SYNC trusts lane 0 of the word itself; CHECK uses the prediction
   assign ref_base = (state == CHK_CHECK) ? exp_base : cand;

   for (genvar i = 0; i < NUM_LANE; i++) begin : g_lane
      assign active[i] = mode96 || (i < NUM_LANE / 2);
      pkt_lane_cmp #(
         .LANE_IDX (i)
      ) u_cmp (
         .word   (data[LANE_W*i +: LANE_W]),
         .base   (ref_base),
         .active (active[i]),
         .mism   (mism[i])
      );
   end

   assign consistent = ~|mism;
   assign any_err    = |mism;

   always_comb begin
      match_nxt = '0;
      if (consistent && (match_cnt == '0 || cand == exp_base))
         match_nxt = match_cnt + 1'b1;
      else if (consistent)
         match_nxt = MC_W'(1);
      run_nxt = any_err ? err_run + 1'b1 : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= CHK_IDLE;
         mode96       <= 1'b0;
         exp_base     <= '0;
         match_cnt    <= '0;
         err_run      <= '0;
         chk_lane_err <= '0;
         chk_err_cnt  <= '0;
         chk_word_cnt <= '0;
      end else begin
         if (!rf_chk_en) begin
            state <= CHK_IDLE;
         end else if (state == CHK_IDLE) begin
            state        <= CHK_SYNC;
            mode96       <= rf_96path_en;
            match_cnt    <= '0;
            chk_lane_err <= '0;
            chk_err_cnt  <= '0;
            chk_word_cnt <= '0;
         end else if (rf_96path_en != mode96) begin
            // lane count changed under us: resynchronise in new mode
            state     <= CHK_SYNC;
            mode96    <= rf_96path_en;
            match_cnt <= '0;
         end else if (data_vld) begin
            if (state == CHK_SYNC) begin
               match_cnt <= match_nxt;
               exp_base  <= cand + step;
               if (match_nxt == MC_W'(SYNC_CNT)) begin
                  state   <= CHK_CHECK;
                  err_run <= '0;
               end
            end else begin
               chk_lane_err <= chk_lane_err | mism;
               if (any_err && chk_err_cnt != '1)
                  chk_err_cnt <= chk_err_cnt + 1'b1;
               if (chk_word_cnt != '1)
                  chk_word_cnt <= chk_word_cnt + 1'b1;
               err_run  <= run_nxt;
               exp_base <= exp_base + step;
               if (run_nxt == ER_W'(ERR_LIMIT)) begin
                  state     <= CHK_SYNC;
                  match_cnt <= '0;
               end
            end
         end
         // clear overrides any update made to the counters this cycle
         if (rf_chk_clr) begin
            chk_lane_err <= '0;
            chk_err_cnt  <= '0;
            chk_word_cnt <= '0;
         end
      end
   end

   assign chk_state  = state;
   assign chk_locked = (state == CHK_CHECK);

endmodule

// File: doc/package_data_chk.md
Name: package_data_chk

Overview:
- Self-test receive-side checker for the ADC capture packaging path.
- Consumes the 24 selected lane words (36 bit each) after packaging/capture, while the chip runs with self-test data from the packet generator.
- Checks them against the deterministic packet-generator ramp pattern in either 96-path (24 lanes) or 48-path (12 lanes) mode.
- Reports lock, per-lane sticky errors, and error/word counters to the register file.

Parameters:
- NUM_LANE, 24, number of 36-bit lanes on the data bus.
- SMP_W, 12, sample width; three samples per 36-bit lane word.
- SYNC_CNT, 4, consecutive consistent words required to declare lock.
- ERR_LIMIT, 8, consecutive erroneous words in CHECK that force a return to SYNC.

Ports:
- clk, input, 1, capture-domain clock.
- rst_n, input, 1, reset: asynchronous assert, active-low.
- rf_chk_en, input, 1, checker enable (level).
- rf_chk_clr, input, 1, one-cycle pulse; clears counters and the sticky mask.
- rf_96path_en, input, 1, 1 = 24 active lanes; 0 = 12 active lanes, lanes 12-23 must be zero.
- data_vld, input, 1, bus qualifier.
- data, input, NUM_LANE*36, lane i at [36*i+35:36*i].
- chk_state, output, 2, 0 = IDLE, 1 = SYNC, 2 = CHECK.
- chk_locked, output, 1, high while in CHECK.
- chk_lane_err, output, NUM_LANE, sticky per-lane mismatch flags.
- chk_err_cnt, output, 16, count of erroneous words, saturating.
- chk_word_cnt, output, 32, count of words checked in CHECK, saturating.

Behaviour:
- **Reset values:** all outputs 0; state IDLE; exp_base 0; match_cnt 0; err_run 0.
- **Pattern:**
  - Lane word bits [11:0], [23:12], [35:24] hold samples k = 0, 1, 2.
  - Sample k of lane i = (base + 3*i + k) mod 2^SMP_W.
  - base advances by STEP = 3*NL per valid word (mod 2^SMP_W), where NL = 24 if rf_96path_en else 12.
  - In 48-path mode, lanes NL..23 must be all-zero; a nonzero inactive lane is an error on that lane.
- **Word consistency:** a word is "consistent" if every active lane matches the pattern using cand = lane0 sample0, and inactive lanes are zero.
- **State transitions:**
  - IDLE: leave to SYNC when rf_chk_en = 1. Counters hold their values in IDLE.
  - Any state goes to IDLE on the next cycle when rf_chk_en = 0.
  - Any state goes to SYNC when rf_96path_en changes while enabled; the mode is registered on each SYNC entry.
- **SYNC, on each data_vld:**
  - If consistent and (match_cnt = 0 or cand = exp_base): match_cnt += 1.
  - Else if consistent: match_cnt = 1.
  - Else: match_cnt = 0.
  - exp_base <= cand + STEP.
  - When match_cnt reaches SYNC_CNT, go to CHECK and clear err_run.
  - No error counting or sticky updates in SYNC.
- **CHECK, on each data_vld:**
  - Compare all lanes against exp_base.
  - Set chk_lane_err[i] for each mismatching lane.
  - If any lane mismatches: chk_err_cnt += 1 (saturate at 0xFFFF) and err_run += 1; otherwise err_run = 0.
  - chk_word_cnt += 1 (saturate at 0xFFFF_FFFF).
  - exp_base += STEP unconditionally (no realignment).
  - When err_run reaches ERR_LIMIT, go to SYNC with match_cnt = 0.
- **No data_vld:** state and counters hold.
- **Counter clearing:**
  - rf_chk_clr zeroes chk_err_cnt, chk_word_cnt and chk_lane_err; state is unaffected.
  - If clear coincides with a checked word, clear wins and that word is not counted.
  - Entering SYNC from IDLE also zeroes the counters and the sticky mask.
- **Latency:**
  - Outputs are registered and reflect a word one cycle after its data_vld.
  - chk_locked rises in the cycle after the SYNC_CNT-th consistent word.
- **Wrap-around:** all sample arithmetic is modulo 4096; base 0xFF0 followed by 0x038 (24-lane STEP = 72) is legal.

Decomposition:
- Shared pktctrl package holds:
  - state encodings CHK_IDLE / CHK_SYNC / CHK_CHECK;
  - LANE_W = 36 and SMP_W = 12;
  - STEP constants 72 and 36.
- One sub-module, pkt_lane_cmp: combinational compare of one 36-bit lane word against a base plus lane index, including the inactive-lane zero check. It is instantiated NUM_LANE times by generate.

Test Plan:
- **96-path lock:** enable, rf_96path_en = 1, ramp from base 0x000 with one word per cycle -> chk_locked = 1 after the 4th word; after 100 more words, chk_word_cnt = 100, chk_err_cnt = 0, chk_lane_err = 0.
- **48-path error detection:** rf_96path_en = 0, ramp with STEP 36 and lanes 12-23 zero -> locked; then force lane 15 = 0x1 for one word -> chk_lane_err = 0x008000, chk_err_cnt = 1, still locked.
- **Single-lane corruption:** flip bit 0 of lane 5 sample 2 in one word -> chk_lane_err[5] = 1, chk_err_cnt = 1, next clean word leaves err_cnt unchanged.
- **Lock loss:** 8 consecutive corrupted words in CHECK -> chk_state = SYNC, chk_locked = 0; clean ramp resumes -> relock after 4 words.
- **Wrap and gaps:** start base 0xFF0 with data_vld toggling 1-0-1 -> no errors across the 0xFFF -> 0x000 wrap; counters hold on idle cycles.
- **Clear, mode change and reset:**
  - rf_chk_clr in the same cycle as an erroneous word -> counters 0 afterwards.
  - Toggling rf_96path_en while locked -> SYNC.
  - rst_n asserted mid-CHECK -> all outputs 0 immediately (asynchronous).
